// File: rtl/logic_sweep_pkg.sv
// rtl/logic_sweep_pkg.sv - mode/state encodings and the reference gate function for the sweep checker
package logic_sweep_pkg;

    localparam int MAX_N = 16;

    typedef enum logic [1:0] {
        MODE_AND  = 2'd0,
        MODE_OR   = 2'd1,
        MODE_XOR  = 2'd2,
        MODE_NAND = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Reduction over the low `width` bits only, so AND/NAND ignore the zero padding.
    function automatic logic expected_y(input mode_e mode, input logic [MAX_N-1:0] vec,
                                        input int width);
        logic v_and;
        logic v_or;
        logic v_xor;
        v_and = 1'b1;
        v_or  = 1'b0;
        v_xor = 1'b0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < width) begin
                v_and = v_and & vec[i];
                v_or  = v_or  | vec[i];
                v_xor = v_xor ^ vec[i];
            end
        end
        case (mode)
            MODE_AND:  return v_and;
            MODE_OR:   return v_or;
            MODE_XOR:  return v_xor;
            default:   return ~v_and;
        endcase
    endfunction

endpackage

// File: rtl/sweep_delay_line.sv
// rtl/sweep_delay_line.sv - DEPTH-stage register pipe with async clear; DEPTH 0 is a wire
module sweep_delay_line #(
    parameter int DEPTH = 0,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_clk;
            assign w_unused_clk = clk ^ rst_n;
            assign o_data       = i_data;
        end else begin : g_pipe
            logic [W-1:0] r_pipe [DEPTH];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign o_data = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/logic_sweep_checker.sv
// rtl/logic_sweep_checker.sv - exhaustive N-bit sweep of a gate under test with latency-aligned compare
module logic_sweep_checker
    import logic_sweep_pkg::*;
#(
    parameter int N   = 2,
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic         dut_y,
    output logic [N-1:0] stim,
    output logic         stim_valid,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic [N-1:0] first_fail,
    output logic         first_fail_valid
);

    localparam logic [N-1:0] STIM_LAST  = '1;
    localparam logic [2:0]   DRAIN_LAST = 3'(LAT > 0 ? LAT - 1 : 0);

    state_e           r_state;
    mode_e            r_mode;
    logic [2:0]       r_drain_cnt;

    logic [MAX_N-1:0] w_stim16;
    logic             w_exp;
    logic [N+1:0]     w_dl_in;
    logic [N+1:0]     w_dl_out;
    logic             w_cmp_valid;
    logic             w_cmp_exp;
    logic [N-1:0]     w_cmp_vec;
    logic             w_mismatch;
    logic [N:0]       w_err_next;

    always_comb begin
        w_stim16        = '0;
        w_stim16[N-1:0] = stim;
    end

    assign w_exp   = expected_y(r_mode, w_stim16, N);
    assign w_dl_in = {stim_valid, w_exp, stim};

    sweep_delay_line #(
        .DEPTH (LAT),
        .W     (N + 2)
    ) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (w_dl_in),
        .o_data (w_dl_out)
    );

    assign w_cmp_valid = w_dl_out[N+1];
    assign w_cmp_exp   = w_dl_out[N];
    assign w_cmp_vec   = w_dl_out[N-1:0];
    // Case inequality so an X/Z from the gate under test is flagged in simulation.
    assign w_mismatch  = w_cmp_valid && (dut_y !== w_cmp_exp);
    assign w_err_next  = err_count + (N+1)'(w_mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_mode           <= MODE_AND;
            r_drain_cnt      <= '0;
            stim             <= '0;
            stim_valid       <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_mismatch) begin
                err_count <= w_err_next;
                if (!first_fail_valid) begin
                    first_fail       <= w_cmp_vec;
                    first_fail_valid <= 1'b1;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode           <= mode_e'(mode);
                        err_count        <= '0;
                        first_fail       <= '0;
                        first_fail_valid <= 1'b0;
                        pass             <= 1'b0;
                        stim             <= '0;
                        stim_valid       <= 1'b1;
                        busy             <= 1'b1;
                        r_state          <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stim == STIM_LAST) begin
                        stim_valid  <= 1'b0;
                        r_drain_cnt <= '0;
                        if (LAT > 0) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (w_err_next == '0);
                        end
                    end else begin
                        stim <= stim + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (w_err_next == '0);
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_sweep_checker.sv
// tb/tb_logic_sweep_checker.sv - scoreboard bench over three checker instances (N=2/3/4)
module tb_logic_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] mode;
    logic       start2, start3, start4;
    logic       g3_stuck;

    logic [1:0] stim2;  logic [2:0] err2;  logic [1:0] ff2;
    logic [2:0] stim3;  logic [3:0] err3;  logic [2:0] ff3;
    logic [3:0] stim4;  logic [4:0] err4;  logic [3:0] ff4;
    logic sv2, busy2, done2, pass2, ffv2, y2;
    logic sv3, busy3, done3, pass3, ffv3, y3;
    logic sv4, busy4, done4, pass4, ffv4, y4;
    logic g4_r1, g4_r2;

    assign y2 = &stim2;
    assign y3 = g3_stuck ? 1'b0 : |stim3;
    always_ff @(posedge clk) begin
        g4_r1 <= ^stim4;
        g4_r2 <= g4_r1;
    end
    assign y4 = g4_r2;

    logic_sweep_checker #(.N(2), .LAT(0)) u_n2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode), .dut_y(y2),
        .stim(stim2), .stim_valid(sv2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_fail(ff2), .first_fail_valid(ffv2));
    logic_sweep_checker #(.N(3), .LAT(0)) u_n3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode), .dut_y(y3),
        .stim(stim3), .stim_valid(sv3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_fail(ff3), .first_fail_valid(ffv3));
    logic_sweep_checker #(.N(4), .LAT(2)) u_n4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode), .dut_y(y4),
        .stim(stim4), .stim_valid(sv4), .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .first_fail(ff4), .first_fail_valid(ffv4));

    int sel;
    logic [15:0] m_stim, m_ff;
    logic [16:0] m_err;
    logic        m_valid, m_busy, m_done, m_pass, m_ffv;

    always_comb begin
        m_stim = '0; m_ff = '0; m_err = '0;
        m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_ffv = 1'b0;
        case (sel)
            2: begin m_stim = 16'(stim2); m_ff = 16'(ff2); m_err = 17'(err2);
                     m_valid = sv2; m_busy = busy2; m_done = done2; m_pass = pass2; m_ffv = ffv2; end
            3: begin m_stim = 16'(stim3); m_ff = 16'(ff3); m_err = 17'(err3);
                     m_valid = sv3; m_busy = busy3; m_done = done3; m_pass = pass3; m_ffv = ffv3; end
            4: begin m_stim = 16'(stim4); m_ff = 16'(ff4); m_err = 17'(err4);
                     m_valid = sv4; m_busy = busy4; m_done = done4; m_pass = pass4; m_ffv = ffv4; end
            default: ;
        endcase
    end

    typedef struct {
        int err;
        int ff;
        bit ffv;
        bit pass;
        int done_edge;
    } exp_t;

    exp_t res_q[$];
    int   stim_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_y(input logic [1:0] md, input int v, input int n);
        case (md)
            2'd0:    return v == (1 << n) - 1;
            2'd1:    return v != 0;
            2'd2:    return $countones(v) % 2 == 1;
            default: return v != (1 << n) - 1;
        endcase
    endfunction

    function automatic bit gate_model(input int s, input int v);
        case (s)
            2:       return v == 3;
            3:       return g3_stuck ? 1'b0 : (v != 0);
            default: return $countones(v) % 2 == 1;
        endcase
    endfunction

    task automatic set_start(input bit v);
        start2 = (sel == 2) && v;
        start3 = (sel == 3) && v;
        start4 = (sel == 4) && v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sweep(input int s, input int n, input int lat, input logic [1:0] md,
                             input int restart_edge, input int mode_edge, input logic [1:0] md2);
        exp_t e;
        int   err = 0, ff = 0, edge_i = 0, done_edge = -1, n_done = 0;
        int   busy_cnt = 0, drain_cnt = 0, exp_v;
        bit   ffv = 0;
        sel = s;
        for (int v = 0; v < (1 << n); v++) begin
            stim_q.push_back(v);
            if (gate_model(s, v) != ref_y(md, v, n)) begin
                err++;
                if (!ffv) begin ff = v; ffv = 1; end
            end
        end
        e = '{err, ff, ffv, (err == 0), (1 << n) + lat};
        res_q.push_back(e);
        mode = md;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        while (edge_i < (1 << n) + lat + 8) begin
            if (m_valid) begin
                check_eq("stim_expected", stim_q.size() != 0, 1);
                if (stim_q.size() != 0) begin
                    exp_v = stim_q.pop_front();
                    check_eq("stim", m_stim, exp_v);
                end
            end
            if (m_busy) busy_cnt++;
            if (m_busy && !m_valid) drain_cnt++;
            if (m_done) begin
                n_done++;
                if (done_edge < 0) done_edge = edge_i;
            end
            set_start(edge_i + 1 == restart_edge);
            if (edge_i + 1 == mode_edge) mode = md2;
            tick();
            edge_i++;
        end
        check_eq("stim_all_seen", stim_q.size(), 0);
        stim_q.delete();
        check_eq("done_count", n_done, 1);
        check_eq("busy_cycles", busy_cnt, (1 << n) + lat);
        check_eq("drain_cycles", drain_cnt, lat);
        check_eq("result_expected", res_q.size() != 0, 1);
        if (res_q.size() != 0) begin
            e = res_q.pop_front();
            check_eq("done_edge", done_edge, e.done_edge);
            check_eq("err_count", m_err, e.err);
            check_eq("first_fail", m_ff, e.ff);
            check_eq("first_fail_valid", m_ffv, e.ffv);
            check_eq("pass", m_pass, e.pass);
        end
    endtask

    initial begin
        int n_done;
        rst_n = 1'b0; mode = 2'd0; g3_stuck = 1'b0; sel = 2;
        start2 = 1'b0; start3 = 1'b0; start4 = 1'b0;
        for (int s = 2; s <= 4; s++) begin
            sel = s;
            #1;
            check_eq("reset_outputs", {m_stim, m_valid, m_busy, m_done, m_pass, m_err, m_ff, m_ffv}, '0);
        end
        tick();
        rst_n = 1'b1;
        tick();

        run_sweep(2, 2, 0, 2'd0, -1, -1, 2'd0);     // AND gate, AND mode
        run_sweep(2, 2, 0, 2'd3, -1, -1, 2'd0);     // AND gate, NAND mode
        g3_stuck = 1'b1;
        run_sweep(3, 3, 0, 2'd1, -1, -1, 2'd0);     // stuck-at-0, OR mode
        g3_stuck = 1'b0;
        run_sweep(4, 4, 2, 2'd2, -1, -1, 2'd0);     // registered XOR, XOR mode
        run_sweep(4, 4, 2, 2'd3, -1, -1, 2'd0);     // registered XOR, NAND mode
        run_sweep(3, 3, 0, 2'd1, 3, 4, 2'd0);       // restart and mode change ignored

        sel = 4; mode = 2'd2;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("midsweep_reset_outputs",
                 {m_stim, m_valid, m_busy, m_done, m_pass, m_err, m_ff, m_ffv}, '0);
        n_done = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (m_done) n_done++; end
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin tick(); if (m_done) n_done++; end
        check_eq("no_done_after_reset", n_done, 0);
        check_eq("idle_after_reset", {m_busy, m_valid, m_err}, '0);
        run_sweep(4, 4, 2, 2'd2, -1, -1, 2'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
